// File: rtl/disp_res_pkg.sv
// Shared types and helpers for the display resolution-change scheduler.
// Holds the FSM state type, reset geometry and the cut-code lookup.
package disp_res_pkg;

  localparam logic [10:0] DEF_MAX_W = 11'd1920;
  localparam logic [10:0] DEF_MAX_H = 11'd1080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PEND,
    ST_COMMIT,
    ST_SETTLE
  } state_e;

  // Pixels trimmed from the source edge for each cut code.
  function automatic logic [10:0] cut_th(input logic [1:0] code);
    case (code)
      2'b01:   return 11'd50;
      2'b10:   return 11'd100;
      default: return 11'd0;
    endcase
  endfunction

endpackage

// File: rtl/disp_res_ctrl_if.sv
// Request-side bundle of the resolution scheduler: strobe/ready handshake,
// requested geometry, source geometry, cut codes and the reject pulse.
interface disp_res_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_width;
  logic [10:0] req_height;
  logic [10:0] src_width;
  logic [10:0] src_height;
  logic [1:0]  req_cut_w;
  logic [1:0]  req_cut_h;
  logic        req_err;

  modport master (
    output req_valid, req_width, req_height, src_width, src_height,
           req_cut_w, req_cut_h,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_width, req_height, src_width, src_height,
           req_cut_w, req_cut_h,
    output req_ready, req_err
  );
endinterface

// File: rtl/disp_res_calc.sv
// Combinational effective-geometry calculation: cut subtraction clamped at
// zero, minimum against the requested size, and legal-range check.
module disp_res_calc
  import disp_res_pkg::*;
#(
  parameter logic [10:0] MIN_W = 11'd64,
  parameter logic [10:0] MIN_H = 11'd32,
  parameter logic [10:0] MAX_W = DEF_MAX_W,
  parameter logic [10:0] MAX_H = DEF_MAX_H
) (
  input  logic [10:0] src_w_i,
  input  logic [10:0] src_h_i,
  input  logic [10:0] req_w_i,
  input  logic [10:0] req_h_i,
  input  logic [1:0]  cut_w_i,
  input  logic [1:0]  cut_h_i,
  output logic [10:0] eff_w_o,
  output logic [10:0] eff_h_o,
  output logic        ok_o
);

  logic [10:0] th_w, th_h, cut_w, cut_h;

  assign th_w = cut_th(cut_w_i);
  assign th_h = cut_th(cut_h_i);

  // A cut at least as large as the source leaves nothing rather than wrapping.
  assign cut_w = (th_w >= src_w_i) ? 11'd0 : src_w_i - th_w;
  assign cut_h = (th_h >= src_h_i) ? 11'd0 : src_h_i - th_h;

  assign eff_w_o = (cut_w < req_w_i) ? cut_w : req_w_i;
  assign eff_h_o = (cut_h < req_h_i) ? cut_h : req_h_i;

  assign ok_o = (eff_w_o >= MIN_W) && (eff_w_o <= MAX_W) &&
                (eff_h_o >= MIN_H) && (eff_h_o <= MAX_H);

endmodule

// File: rtl/disp_res_ctrl.sv
// Resolution-change scheduler: validates requests and commits them on a frame
// boundary (or timeout). Optional statistics under DISP_RES_CTRL_STATS_EN.
module disp_res_ctrl
  import disp_res_pkg::*;
#(
  parameter logic [10:0] MIN_W   = 11'd64,
  parameter logic [10:0] MIN_H   = 11'd32,
  parameter logic [10:0] MAX_W   = DEF_MAX_W,
  parameter logic [10:0] MAX_H   = DEF_MAX_H,
  parameter logic [23:0] TIMEOUT = 24'd4000000,
  parameter logic [3:0]  SETTLE  = 4'd8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  disp_res_ctrl_if.slave    req_if,
  input  logic              vs_in,
  output logic              change_valid,
  output logic [10:0]       width_act,
  output logic [10:0]       height_act,
  output logic              busy
`ifdef DISP_RES_CTRL_STATS_EN
  ,
  output logic [15:0]       commit_cnt,
  output logic [7:0]        timeout_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;
  localparam logic [23:0] ST_LAST = {20'd0, SETTLE} - 24'd1;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [10:0] cap_w_q, cap_h_q;
  logic        cap_ok_q;
  logic [10:0] act_w_q, act_h_q;
  logic        vs_q;

  logic [10:0] calc_w, calc_h;
  logic        calc_ok;
  logic        accept, vs_edge, to_hit;

  disp_res_calc #(
    .MIN_W(MIN_W), .MIN_H(MIN_H), .MAX_W(MAX_W), .MAX_H(MAX_H)
  ) u_calc (
    .src_w_i (req_if.src_width),
    .src_h_i (req_if.src_height),
    .req_w_i (req_if.req_width),
    .req_h_i (req_if.req_height),
    .cut_w_i (req_if.req_cut_w),
    .cut_h_i (req_if.req_cut_h),
    .eff_w_o (calc_w),
    .eff_h_o (calc_h),
    .ok_o    (calc_ok)
  );

  assign accept  = req_if.req_valid && (state_q == ST_IDLE);
  assign vs_edge = vs_in & ~vs_q;
  assign to_hit  = (cnt_q == TO_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      vs_q     <= 1'b0;
      cap_w_q  <= MAX_W;
      cap_h_q  <= MAX_H;
      cap_ok_q <= 1'b0;
      act_w_q  <= MAX_W;
      act_h_q  <= MAX_H;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vs_q    <= vs_in;
      if (accept) begin
        cap_w_q  <= calc_w;
        cap_h_q  <= calc_h;
        cap_ok_q <= calc_ok;
      end
      if (state_q == ST_COMMIT) begin
        act_w_q <= cap_w_q;
        act_h_q <= cap_h_q;
      end
    end
  end

  // One counter serves both the pending timeout and the settle interval;
  // it is cleared on entry to each of those states.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!cap_ok_q) begin
          state_d = ST_IDLE;
        end else if ((cap_w_q == act_w_q) && (cap_h_q == act_h_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
          cnt_d   = 24'd0;
        end
      end
      ST_PEND: begin
        if (vs_edge || to_hit) begin
          state_d = ST_COMMIT;
        end else if (cnt_q != 24'hFF_FFFF) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_SETTLE;
        cnt_d   = 24'd0;
      end
      ST_SETTLE: begin
        if (cnt_q == ST_LAST) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q + 24'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_if.req_ready = (state_q == ST_IDLE);
  assign req_if.req_err   = (state_q == ST_CHECK) && !cap_ok_q;
  assign change_valid     = (state_q == ST_COMMIT);
  assign busy             = (state_q != ST_IDLE);
  assign width_act        = act_w_q;
  assign height_act       = act_h_q;

`ifdef DISP_RES_CTRL_STATS_EN
  logic [15:0] commit_cnt_q;
  logic [7:0]  timeout_cnt_q, err_cnt_q;
  logic        forced;

  // A commit counts as forced only when no vsync edge arrived with it.
  assign forced = (state_q == ST_PEND) && to_hit && !vs_edge;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      commit_cnt_q  <= 16'd0;
      timeout_cnt_q <= 8'd0;
      err_cnt_q     <= 8'd0;
    end else begin
      if (change_valid && (commit_cnt_q != 16'hFFFF))
        commit_cnt_q <= commit_cnt_q + 16'd1;
      if (forced && (timeout_cnt_q != 8'hFF))
        timeout_cnt_q <= timeout_cnt_q + 8'd1;
      if (req_if.req_err && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign commit_cnt  = commit_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule
